// File: rtl/lsu_pkg.sv
// Shared encodings and decode helpers for the RV32I load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] STRB_WORD  = 3'b000;
    localparam logic [2:0] STRB_LO_H  = 3'b001;
    localparam logic [2:0] STRB_NOP   = 3'b010;
    localparam logic [2:0] STRB_HI_H  = 3'b011;
    localparam logic [2:0] STRB_BYTE0 = 3'b100;
    localparam logic [2:0] STRB_BYTE1 = 3'b101;
    localparam logic [2:0] STRB_BYTE2 = 3'b110;
    localparam logic [2:0] STRB_BYTE3 = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALIGNED = 2'd1,
        MIS     = 2'd2,
        ERR     = 2'd3
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // f3[1:0] carries the access size for every legal encoding.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] aligned_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b10:   return STRB_WORD;
            2'b01:   return off[1] ? STRB_HI_H : STRB_LO_H;
            default: return {1'b1, off};
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Selects the addressed byte/half of a word and sign- or zero-extends it.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'h0, byte_sel};
            F3_HU:   data_o = {16'h0, half_sel};
            default: data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// RV32I load/store port to a word-addressed memory; misaligned accesses are
// split into sequential single-byte operations.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter  int unsigned DEPTH = 128,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [31:0]   mem_rd_dout,
    output logic [AW-1:0] mem_wr_addr,
    output logic [31:0]   mem_wr_din,
    output logic          mem_we,
    output logic [2:0]    mem_wr_strb
);

    // Only the byte address bits that reach the word address are kept.
    localparam int unsigned BW = AW + 2;

    lsu_state_e    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    f3_q, f3_d;
    logic [BW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [23:0]   asm_q, asm_d;

    logic [BW-1:0] byte_addr;
    logic [1:0]    lane;
    logic [7:0]    cur_byte;
    logic          last_byte;
    logic          we_raw;
    logic [31:0]   ext_word;
    logic [1:0]    ext_off;
    logic [31:0]   ext_data;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:BW];

    assign byte_addr = addr_q + BW'(cnt_q);
    assign lane      = byte_addr[1:0];
    assign cur_byte  = mem_rd_dout[{lane, 3'b000} +: 8];
    assign last_byte = cnt_q == ((f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3);

    lsu_load_extend u_ext (
        .word_i   (ext_word),
        .off_i    (ext_off),
        .funct3_i (f3_q),
        .data_o   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            cnt_q   <= 2'd0;
            asm_q   <= 24'h0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = 32'h0;
        resp_err    = 1'b0;
        mem_rd_addr = '0;
        mem_wr_din  = 32'h0;
        we_raw      = 1'b0;
        mem_wr_strb = STRB_NOP;
        ext_word    = mem_rd_dout;
        ext_off     = addr_q[1:0];

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr[BW-1:0];
                    wdata_d = req_wdata;
                    cnt_d   = 2'd0;
                    asm_d   = 24'h0;
                    if (!f3_legal(req_we, req_funct3)) begin
                        state_d = ERR;
                    end else if (is_misaligned(req_funct3[1:0], req_addr[1:0])) begin
                        state_d = MIS;
                    end else begin
                        state_d = ALIGNED;
                    end
                end
            end
            ALIGNED: begin
                mem_rd_addr = addr_q[BW-1:2];
                resp_valid  = 1'b1;
                if (we_q) begin
                    we_raw      = 1'b1;
                    mem_wr_din  = wdata_q;
                    mem_wr_strb = aligned_strb(f3_q[1:0], addr_q[1:0]);
                end else begin
                    resp_rdata = ext_data;
                end
                state_d = IDLE;
            end
            MIS: begin
                mem_rd_addr = byte_addr[BW-1:2];
                if (we_q) begin
                    we_raw      = 1'b1;
                    mem_wr_strb = {1'b1, lane};
                    mem_wr_din  = {24'h0, wdata_q[{cnt_q, 3'b000} +: 8]};
                end else begin
                    case (cnt_q)
                        2'd0:    asm_d[7:0]   = cur_byte;
                        2'd1:    asm_d[15:8]  = cur_byte;
                        2'd2:    asm_d[23:16] = cur_byte;
                        default: asm_d        = asm_q;
                    endcase
                    // Final byte comes straight from memory; earlier ones from asm_q.
                    ext_word = (f3_q[1:0] == 2'b01) ? {16'h0, cur_byte, asm_q[7:0]}
                                                    : {cur_byte, asm_q};
                    ext_off  = 2'b00;
                end
                if (last_byte) begin
                    resp_valid = 1'b1;
                    if (!we_q) begin
                        resp_rdata = ext_data;
                    end
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we      = we_raw & ~rst;
    assign mem_wr_addr = mem_rd_addr;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a behavioural 128-word strobed memory.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [6:0]  mem_rd_addr, mem_wr_addr;
    logic [31:0] mem_rd_dout, mem_wr_din;
    logic        mem_we;
    logic [2:0]  mem_wr_strb;

    logic [31:0] mem [128];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [6:0]  mis_addr [4];
    logic [2:0]  mis_strb [4];
    logic [7:0]  mis_din  [4];

    always #5 clk = ~clk;

    lsu_mem_port #(.DEPTH(128)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_dout (mem_rd_dout),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_din  (mem_wr_din),
        .mem_we      (mem_we),
        .mem_wr_strb (mem_wr_strb)
    );

    assign mem_rd_dout = mem[mem_rd_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_wr_strb)
                3'b000:  mem[mem_wr_addr]        <= mem_wr_din;
                3'b001:  mem[mem_wr_addr][15:0]  <= mem_wr_din[15:0];
                3'b011:  mem[mem_wr_addr][31:16] <= mem_wr_din[15:0];
                3'b010:  ;
                default: mem[mem_wr_addr][{mem_wr_strb[1:0], 3'b000} +: 8] <= mem_wr_din[7:0];
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request from IDLE; returns in the first access cycle.
    task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
        chk("req_ready_before_accept", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        step();
        req_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mis_addr[0] = 7'd1; mis_strb[0] = 3'b101; mis_din[0] = 8'h44;
        mis_addr[1] = 7'd1; mis_strb[1] = 3'b110; mis_din[1] = 8'h33;
        mis_addr[2] = 7'd1; mis_strb[2] = 3'b111; mis_din[2] = 8'h22;
        mis_addr[3] = 7'd2; mis_strb[3] = 3'b100; mis_din[3] = 8'h11;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        step();
        step();
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0;
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        chk("idle_resp_valid", 32'(resp_valid), 32'd0);
        chk("idle_resp_rdata", resp_rdata, 32'h0);
        chk("idle_resp_err", 32'(resp_err), 32'd0);
        chk("idle_mem_we", 32'(mem_we), 32'd0);
        chk("idle_strb", 32'(mem_wr_strb), 32'd2);
        chk("idle_addr", 32'(mem_rd_addr), 32'd0);

        // Aligned word store / load
        req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
        chk("sw_we", 32'(mem_we), 32'd1);
        chk("sw_addr", 32'(mem_wr_addr), 32'd2);
        chk("sw_strb", 32'(mem_wr_strb), 32'd0);
        chk("sw_din", mem_wr_din, 32'hDEADBEEF);
        chk("sw_valid", 32'(resp_valid), 32'd1);
        chk("sw_ready_busy", 32'(req_ready), 32'd0);
        step();
        req(1'b0, 3'b010, 32'h8, 32'h0);
        chk("lw_valid", 32'(resp_valid), 32'd1);
        chk("lw_rdata", resp_rdata, 32'hDEADBEEF);
        chk("lw_err", 32'(resp_err), 32'd0);
        chk("lw_mem_we", 32'(mem_we), 32'd0);
        step();

        // Byte store, signed/unsigned byte loads
        req(1'b1, 3'b000, 32'h7, 32'h81);
        chk("sb_strb", 32'(mem_wr_strb), 32'd7);
        chk("sb_addr", 32'(mem_wr_addr), 32'd1);
        chk("sb_we", 32'(mem_we), 32'd1);
        step();
        req(1'b0, 3'b000, 32'h7, 32'h0);
        chk("lb_rdata", resp_rdata, 32'hFFFFFF81);
        step();
        req(1'b0, 3'b100, 32'h7, 32'h0);
        chk("lbu_rdata", resp_rdata, 32'h00000081);
        step();

        // High-half store, signed/unsigned half loads
        req(1'b1, 3'b001, 32'h2, 32'hA5C3);
        chk("sh_strb", 32'(mem_wr_strb), 32'd3);
        chk("sh_addr", 32'(mem_wr_addr), 32'd0);
        step();
        req(1'b0, 3'b001, 32'h2, 32'h0);
        chk("lh_rdata", resp_rdata, 32'hFFFFA5C3);
        step();
        req(1'b0, 3'b101, 32'h2, 32'h0);
        chk("lhu_rdata", resp_rdata, 32'h0000A5C3);
        step();

        // Misaligned word store: four byte writes
        req(1'b1, 3'b010, 32'h5, 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mis_sw_addr%0d", i), 32'(mem_wr_addr), 32'(mis_addr[i]));
            chk($sformatf("mis_sw_strb%0d", i), 32'(mem_wr_strb), 32'(mis_strb[i]));
            chk($sformatf("mis_sw_din%0d", i), mem_wr_din, 32'(mis_din[i]));
            chk($sformatf("mis_sw_valid%0d", i), 32'(resp_valid), (i == 3) ? 32'd1 : 32'd0);
            chk($sformatf("mis_sw_ready%0d", i), 32'(req_ready), 32'd0);
            step();
        end
        req(1'b0, 3'b010, 32'h5, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("mis_lw_novalid%0d", i), 32'(resp_valid), 32'd0);
            step();
        end
        chk("mis_lw_valid", 32'(resp_valid), 32'd1);
        chk("mis_lw_rdata", resp_rdata, 32'h11223344);
        step();

        // Misaligned signed half load within word 2 (now 0xDEADBE11)
        req(1'b0, 3'b001, 32'h9, 32'h0);
        chk("mis_lh_novalid", 32'(resp_valid), 32'd0);
        step();
        chk("mis_lh_valid", 32'(resp_valid), 32'd1);
        chk("mis_lh_rdata", resp_rdata, 32'hFFFFADBE);
        step();

        // Half store straddling the top of memory wraps to word 0
        req(1'b1, 3'b001, 32'h1FF, 32'hBEEF);
        chk("wrap_addr0", 32'(mem_wr_addr), 32'd127);
        chk("wrap_strb0", 32'(mem_wr_strb), 32'd7);
        chk("wrap_din0", mem_wr_din, 32'hEF);
        step();
        chk("wrap_addr1", 32'(mem_wr_addr), 32'd0);
        chk("wrap_strb1", 32'(mem_wr_strb), 32'd4);
        chk("wrap_din1", mem_wr_din, 32'hBE);
        chk("wrap_valid", 32'(resp_valid), 32'd1);
        step();
        req(1'b0, 3'b101, 32'h1FF, 32'h0);
        step();
        chk("wrap_lhu_rdata", resp_rdata, 32'h0000BEEF);
        step();

        // Upper address bits ignored: 0x208 aliases word 2
        req(1'b0, 3'b010, 32'h208, 32'h0);
        chk("alias_lw_addr", 32'(mem_rd_addr), 32'd2);
        chk("alias_lw_rdata", resp_rdata, 32'hDEADBE11);
        step();

        // Illegal funct3 store and load
        req(1'b1, 3'b011, 32'h0, 32'hFFFFFFFF);
        chk("ill_st_valid", 32'(resp_valid), 32'd1);
        chk("ill_st_err", 32'(resp_err), 32'd1);
        chk("ill_st_we", 32'(mem_we), 32'd0);
        chk("ill_st_rdata", resp_rdata, 32'h0);
        step();
        req(1'b0, 3'b110, 32'h0, 32'h0);
        chk("ill_ld_err", 32'(resp_err), 32'd1);
        chk("ill_ld_rdata", resp_rdata, 32'h0);
        step();

        // Reset during the second byte of a misaligned store
        req(1'b1, 3'b010, 32'h21, 32'hCAFEF00D);
        chk("rmis_we0", 32'(mem_we), 32'd1);
        chk("rmis_addr0", 32'(mem_wr_addr), 32'd8);
        chk("rmis_strb0", 32'(mem_wr_strb), 32'd5);
        chk("rmis_din0", mem_wr_din, 32'h0D);
        step();
        rst = 1'b1;
        #1;
        chk("rmis_we_gated", 32'(mem_we), 32'd0);
        chk("rmis_novalid", 32'(resp_valid), 32'd0);
        step();
        rst = 1'b0;
        chk("rmis_ready_after", 32'(req_ready), 32'd1);
        chk("rmis_valid_after", 32'(resp_valid), 32'd0);
        req(1'b0, 3'b010, 32'h20, 32'h0);
        chk("rmis_word8", resp_rdata, 32'h00000D00);
        step();
        req(1'b0, 3'b010, 32'h24, 32'h0);
        chk("rmis_word9", resp_rdata, 32'h00000000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
